det_bareiss: RTL and testbench

Parametrised, multi-cycle integer determinant engine for square matrices up to MAX_N×MAX_N with runtime-selectable size. It uses fraction-free Bareiss elimination with row-swap pivoting, and reports the determinant truncated to DATA_W bits plus an overflow flag. It succeeds the fixed 4×4 combinational cofactor unit in the coprocessor datapath and sits behind the same instruction decode, with a start/done handshake instead of a combinational result.

---
 rtl/det_pkg.sv | 30 +++
 rtl/det_bareiss_div.sv | 70 +++++++
 rtl/det_bareiss.sv | 212 +++++++++++++++++++++
 tb/tb_det_bareiss.sv | 125 ++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared types and helpers for the det_bareiss determinant engine.
package det_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_PIVOT,
    S_SCAN,
    S_SWAP,
    S_MUL,
    S_DIV,
    S_FINAL,
    S_DONE
  } state_t;

  // LSB position of element (r,c) in the row-major, MSB-first flat matrix bus.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                           input int unsigned max_n, input int unsigned data_w);
    return (max_n * max_n - 1 - (r * max_n + c)) * data_w;
  endfunction

  function automatic longint det_smax(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint det_smin(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/det_bareiss_div.sv
// Signed restoring divider: 2*ACC_W-bit dividend by ACC_W-bit divisor in ACC_W cycles.
module det_bareiss_div #(
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [2*ACC_W-1:0] i_dividend,
  input  logic [ACC_W-1:0]   i_divisor,
  output logic               o_done,
  output logic [ACC_W-1:0]   o_quot,
  output logic               o_ovf
);

  localparam int CW = $clog2(ACC_W);
  localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] r_rem, r_lo, r_quo, r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_neg, r_hi_ovf;

  logic [2*ACC_W-1:0] w_dnd_abs;
  logic [ACC_W-1:0]   w_dvs_abs, w_diff, w_rem_nx, w_quo_nx;
  logic [ACC_W:0]     w_t;
  logic               w_ge;

  assign w_dnd_abs = i_dividend[2*ACC_W-1] ? -i_dividend : i_dividend;
  assign w_dvs_abs = i_divisor[ACC_W-1] ? -i_divisor : i_divisor;

  assign w_t      = {r_rem, r_lo[ACC_W-1]};
  assign w_ge     = w_t >= {1'b0, r_div};
  assign w_diff   = w_t[ACC_W-1:0] - r_div;
  assign w_rem_nx = w_ge ? w_diff : w_t[ACC_W-1:0];
  assign w_quo_nx = {r_quo[ACC_W-2:0], w_ge};

  // Final quotient bit is formed combinationally so the result is usable in the last cycle.
  assign o_done = r_busy && (r_cnt == CW'(ACC_W - 1));
  assign o_quot = r_neg ? -w_quo_nx : w_quo_nx;
  assign o_ovf  = r_hi_ovf | (r_neg ? (w_quo_nx > HALF) : w_quo_nx[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_lo     <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_neg    <= 1'b0;
      r_hi_ovf <= 1'b0;
    end else if (i_start) begin
      r_rem    <= w_dnd_abs[2*ACC_W-1:ACC_W];
      r_lo     <= w_dnd_abs[ACC_W-1:0];
      r_div    <= w_dvs_abs;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_neg    <= i_dividend[2*ACC_W-1] ^ i_divisor[ACC_W-1];
      // A high half not below the divisor means the quotient needs more than ACC_W bits.
      r_hi_ovf <= w_dnd_abs[2*ACC_W-1:ACC_W] >= w_dvs_abs;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_lo  <= r_lo << 1;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/det_bareiss.sv
// Multi-cycle Bareiss determinant engine with row-swap pivoting.
// Optional macro DET_BAREISS_SAT_EN saturates det on result range overflow.
module det_bareiss
  import det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 4,
  parameter int ACC_W  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_N+1)-1:0]      size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_W-1:0]               det,
  output logic                            ovf
);

  localparam int SZ_W = $clog2(MAX_N + 1);
  localparam int AW   = $clog2(MAX_N);
  localparam int P_W  = 2 * ACC_W;
  localparam int R_W  = ACC_W + 1;
  localparam logic signed [R_W-1:0] DMAX = R_W'(det_smax(DATA_W));
  localparam logic signed [R_W-1:0] DMIN = R_W'(det_smin(DATA_W));

  state_t r_state, w_next;

  logic signed [ACC_W-1:0] r_m [MAX_N][MAX_N];
  logic signed [ACC_W-1:0] r_prev;
  logic [AW-1:0]           r_k, r_i, r_j, r_r;
  logic [SZ_W-1:0]         r_n;
  logic                    r_sign, r_ovf_int, r_ovf;
  logic [DATA_W-1:0]       r_det;

  logic signed [ACC_W-1:0] w_mkk, w_mij, w_mik, w_mkj, w_mrk, w_mlast;
  logic signed [P_W-1:0]   w_p;
  logic signed [R_W-1:0]   w_res;
  logic [SZ_W-1:0]         w_nm1;
  logic [AW-1:0]           w_k1;
  logic [DATA_W-1:0]       w_det_fin;
  logic [ACC_W-1:0]        w_quot;
  logic w_valid, w_last_i, w_last_j, w_last_k, w_scan_last;
  logic w_p_ovf, w_res_oor, w_elem_done, w_div_start, w_div_done, w_div_ovf;
  state_t w_adv;

  assign w_nm1       = r_n - SZ_W'(1);
  assign w_k1        = r_k + AW'(1);
  assign w_valid     = (size != '0) && (size <= SZ_W'(MAX_N));
  assign w_last_i    = (SZ_W'(r_i) == w_nm1);
  assign w_last_j    = (SZ_W'(r_j) == w_nm1);
  assign w_last_k    = (SZ_W'(w_k1) == w_nm1);
  assign w_scan_last = (SZ_W'(r_r) == w_nm1);

  assign w_mkk   = r_m[r_k][r_k];
  assign w_mij   = r_m[r_i][r_j];
  assign w_mik   = r_m[r_i][r_k];
  assign w_mkj   = r_m[r_k][r_j];
  assign w_mrk   = r_m[r_r][r_k];
  assign w_mlast = r_m[w_nm1[AW-1:0]][w_nm1[AW-1:0]];

  assign w_p     = P_W'(w_mkk) * P_W'(w_mij) - P_W'(w_mik) * P_W'(w_mkj);
  assign w_p_ovf = ~(&w_p[P_W-1:ACC_W-1] | ~(|w_p[P_W-1:ACC_W-1]));

  assign w_res     = r_sign ? -R_W'(w_mlast) : R_W'(w_mlast);
  assign w_res_oor = (w_res > DMAX) || (w_res < DMIN);

`ifdef DET_BAREISS_SAT_EN
  assign w_det_fin = w_res_oor ? (w_res[R_W-1] ? DATA_W'(DMIN) : DATA_W'(DMAX))
                               : w_res[DATA_W-1:0];
`else
  assign w_det_fin = w_res[DATA_W-1:0];
`endif

  assign w_div_start = (r_state == S_MUL) && (r_k != '0);
  assign w_elem_done = ((r_state == S_MUL) && (r_k == '0)) || ((r_state == S_DIV) && w_div_done);
  assign w_adv       = (w_last_j && w_last_i) ? (w_last_k ? S_FINAL : S_PIVOT) : S_MUL;

  det_bareiss_div #(.ACC_W(ACC_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_p),
    .i_divisor  (r_prev),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_ovf      (w_div_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (start) w_next = w_valid ? S_LOAD : S_DONE;
      S_LOAD:  w_next = (r_n == SZ_W'(1)) ? S_FINAL : S_PIVOT;
      S_PIVOT: w_next = (w_mkk != '0) ? S_MUL : S_SCAN;
      S_SCAN: begin
        if (w_mrk != '0)      w_next = S_SWAP;
        else if (w_scan_last) w_next = S_DONE;
      end
      S_SWAP:  w_next = S_MUL;
      S_MUL:   w_next = (r_k == '0) ? w_adv : S_DIV;
      S_DIV:   if (w_div_done) w_next = w_adv;
      S_FINAL: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < MAX_N; r++)
        for (int unsigned c = 0; c < MAX_N; c++)
          r_m[r][c] <= '0;
      r_prev    <= '0;
      r_k       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_r       <= '0;
      r_n       <= '0;
      r_sign    <= 1'b0;
      r_ovf_int <= 1'b0;
      r_ovf     <= 1'b0;
      r_det     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (w_valid) begin
            for (int unsigned r = 0; r < MAX_N; r++)
              for (int unsigned c = 0; c < MAX_N; c++)
                r_m[r][c] <= ACC_W'(signed'(matrix[elem_lsb(r, c, MAX_N, DATA_W) +: DATA_W]));
            r_n       <= size;
            r_sign    <= 1'b0;
            r_prev    <= ACC_W'(1);
            r_k       <= '0;
            r_ovf_int <= 1'b0;
          end else begin
            r_det <= '0;
            r_ovf <= 1'b1;
          end
        end
        S_PIVOT: begin
          if (w_mkk != '0) begin
            r_i <= w_k1;
            r_j <= w_k1;
          end else begin
            r_r <= w_k1;
          end
        end
        S_SCAN: begin
          if (w_mrk == '0) begin
            r_r <= r_r + AW'(1);
            if (w_scan_last) begin
              r_det     <= '0;
              r_ovf     <= 1'b0;
              r_ovf_int <= 1'b0;
            end
          end
        end
        S_SWAP: begin
          for (int unsigned c = 0; c < MAX_N; c++)
            if (c[AW-1:0] >= r_k) begin
              r_m[r_k][c] <= r_m[r_r][c];
              r_m[r_r][c] <= r_m[r_k][c];
            end
          r_sign <= ~r_sign;
          r_i    <= w_k1;
          r_j    <= w_k1;
        end
        S_MUL: if (r_k == '0) begin
          r_m[r_i][r_j] <= w_p[ACC_W-1:0];
          if (w_p_ovf) r_ovf_int <= 1'b1;
        end
        S_DIV: if (w_div_done) begin
          r_m[r_i][r_j] <= w_quot;
          if (w_div_ovf) r_ovf_int <= 1'b1;
        end
        S_FINAL: begin
          r_det <= w_det_fin;
          r_ovf <= r_ovf_int | w_res_oor;
        end
        default: ;
      endcase

      // Loop advance: j fastest, then i; a finished sweep closes elimination step k.
      if (w_elem_done) begin
        if (w_last_j) begin
          if (w_last_i) begin
            r_prev <= w_mkk;
            r_k    <= w_k1;
          end else begin
            r_i <= r_i + AW'(1);
            r_j <= w_k1;
          end
        end else begin
          r_j <= r_j + AW'(1);
        end
      end
    end
  end

  assign det = r_det;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_det_bareiss.sv
// Directed self-checking bench for det_bareiss (DATA_W=8, MAX_N=4, ACC_W=32).
module tb_det_bareiss;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   size = '0;
  logic [127:0] matrix = '0;
  logic         busy, done, ovf;
  logic [7:0]   det;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] M_3425   = 128'h03047F7F_02057F7F_7F7F7F7F_7F7F7F7F;
  localparam logic [127:0] M_SWAP   = 128'h00010000_01000000_00000000_00000000;
  localparam logic [127:0] M_SING   = 128'h00010000_00020000_00000000_00000000;
  localparam logic [127:0] M_3X3    = 128'h01020300_02040600_01000100_00000000;
  localparam logic [127:0] M_DIAG10 = 128'h0A000000_000A0000_00000A00_0000000A;
  localparam logic [127:0] M_DIAGN  = 128'hFE000000_00020000_00000200_00000010;

`ifdef DET_BAREISS_SAT_EN
  localparam logic [7:0] EXP_DIAG10 = 8'd127;
`else
  localparam logic [7:0] EXP_DIAG10 = 8'd16;
`endif

  det_bareiss #(.DATA_W(8), .MAX_N(4), .ACC_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .size   (size),
    .matrix (matrix),
    .busy   (busy),
    .done   (done),
    .det    (det),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run in cycle 0, then wait (bounded) for done and check latency and result.
  task automatic run(input string tag, input logic [2:0] n, input logic [127:0] m,
                     input int exp_lat, input logic [7:0] exp_det, input logic exp_ovf,
                     input bit poke);
    int cyc;
    @(negedge clk);
    size   = n;
    matrix = m;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    size   = '0;
    matrix = '0;
    cyc    = 1;
    if (exp_lat > 1) chk({tag, "_busy1"}, busy, 1);
    while (!done && cyc < 400) begin
      start = (poke && cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_det"}, det, exp_det);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, det, exp_det);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det", det, 0);
    chk("rst_ovf", ovf, 0);

    run("det2x2", 3'd2, M_3425, 5, 8'd7, 1'b0, 1'b1);
    run("swap2x2", 3'd2, M_SWAP, 7, 8'hFF, 1'b0, 1'b0);
    run("sing2x2", 3'd2, M_SING, 4, 8'h00, 1'b0, 1'b0);
    run("rank3x3", 3'd3, M_3X3, 44, 8'h00, 1'b0, 1'b0);
    run("diag10", 3'd4, M_DIAG10, 180, EXP_DIAG10, 1'b1, 1'b0);
    run("size0", 3'd0, M_3425, 1, 8'h00, 1'b1, 1'b0);
    run("size5", 3'd5, M_3425, 1, 8'h00, 1'b1, 1'b0);
    run("diagneg", 3'd4, M_DIAGN, 180, 8'h80, 1'b0, 1'b0);

    // Abort a 4x4 run while it sits in the divider.
    @(negedge clk);
    size   = 3'd4;
    matrix = M_DIAG10;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_det", det, 0);
    chk("abort_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nodone", done, 0);

    run("after_abort", 3'd2, M_3425, 5, 8'd7, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
